edge_map_packer: RTL and testbench
==================================

Name: edge_map_packer

Overview:
- Reader/consumer for the edge-map buffer's send mode.
- Accepts the 1-bit-per-pixel thresholded edge stream (one frame, NUM_PIXELS bits) and packs it MSB-first into bytes.
- Queues the bytes in a small FIFO and presents them on a valid/ready byte interface toward the host link (UART/SPI framer).
- Signals frame completion back to control so the buffer can be reset and returned to receive mode.

Parameters:
- NUM_PIXELS, 22500, pixels per frame (150x150); last byte zero-padded if NUM_PIXELS % 8 != 0.
- CNT_W, 15, width of pixel counter; must satisfy 2^CNT_W > NUM_PIXELS.
- FIFO_DEPTH, 4, byte FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- enb  input  1  global enable; low = full stall of both interfaces.
- start  input  1  single-cycle pulse; begins a frame when in IDLE, ignored otherwise.
- bit_in  input  1  edge pixel bit from buffer.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_ready  output  1  packer accepts bit this cycle.
- byte_out  output  8  packed byte, first pixel in bit 7.
- byte_valid  output  1  byte_out valid.
- byte_ready  input  1  downstream accepts byte.
- byte_last  output  1  high with the final byte of the frame.
- pix_cnt  output  CNT_W  pixels accepted in current frame.
- complete  output  1  frame fully drained; held until next start or reset.

Behaviour:
- Reset:
  - All outputs are 0 and the FIFO is empty.
  - state=IDLE, shift register = 0, bit counter (3 bits) = 0.
  - Reset mid-frame discards all partial and queued data.
- Bit accept: accepted when bit_valid && bit_ready && enb.
  - Shift: sreg <= {sreg[6:0], bit_in}.
  - bit_cnt increments mod 8; pix_cnt increments by 1.
- States:
  - IDLE:
    - bit_ready=0, byte_valid=0.
    - On start && enb: clear pix_cnt, bit_cnt, sreg, complete; go PACK.
  - PACK:
    - bit_ready = enb && (bit_cnt != 7 || !fifo_full).
    - On the 8th accepted bit, {sreg[6:0], bit_in} is pushed to the FIFO on the same edge.
    - The push carries last=1 iff that bit is pixel NUM_PIXELS-1.
    - When pixel NUM_PIXELS-1 is accepted:
      - If the byte is complete, go DRAIN.
      - Otherwise go FLUSH.
  - FLUSH:
    - bit_ready=0.
    - When !fifo_full && enb, push sreg << (8 - bit_cnt), i.e. the remaining low bits are zero, with last=1; go DRAIN.
  - DRAIN:
    - bit_ready=0.
    - When the FIFO becomes empty (last byte popped), set complete=1 and go DONE.
  - DONE:
    - complete held at 1.
    - On start && enb: clear complete and counters; go PACK.
- FIFO / output:
  - byte_valid = enb && !fifo_empty.
  - byte_out and byte_last come from the head entry; they are registered storage and stable while byte_valid && !byte_ready.
  - Pop on byte_valid && byte_ready.
  - Push and pop in the same cycle are both permitted when not full; occupancy is unchanged in that case.
  - When full, a push is blocked by bit_ready=0; a same-cycle pop does not unblock it.
- Latency: the byte completed at edge N shows byte_valid=1 in the cycle after edge N if the FIFO was empty (1-cycle latency).
- enb=0: no accept, no push, no pop, no state change; bit_ready=0, byte_valid=0.
- start while in PACK/FLUSH/DRAIN: ignored.
- Extra bit_valid after the final pixel: not accepted (bit_ready=0).
- pix_cnt saturates at NUM_PIXELS for the frame.
- Byte count per frame = ceil(NUM_PIXELS/8); 2813 at default.

Test Plan:
- Default params, start, 22500 bits all 1, byte_ready=1:
  - 2813 bytes total.
  - Bytes 0..2811 are 8'hFF.
  - Byte 2812 is 8'hF0 with byte_last=1.
  - complete=1 one cycle after its pop; pix_cnt=22500.
- NUM_PIXELS=16, bits 1,0,1,1,0,0,0,1, 0,0,0,0,1,1,1,1 -> bytes 8'hB1 then 8'h0F (last=1); no FLUSH state entered.
- NUM_PIXELS=16, FIFO_DEPTH=2, byte_ready=0 throughout:
  - Two bytes queued.
  - bit_ready=0 once bit_cnt=7 with FIFO full.
  - Raising byte_ready drains in order: 8'hB1, 8'h0F.
- Frame in progress (pix_cnt=5), toggle enb=0 for 3 cycles with bit_valid=1: pix_cnt stays 5, byte_valid=0; resume produces correct bytes.
- Assert reset after 10 bits accepted:
  - All outputs 0, FIFO empty, state IDLE.
  - A new start plus 16 bits gives exactly 2 correct bytes.
- In DONE, drive bit_valid=1 with no start: bit_ready=0, no bytes. A start pulse clears complete and begins a new frame.

Source files
------------

// File: rtl/edge_map_packer_if.sv
// rtl/edge_map_packer_if.sv - bit-stream input and byte-stream output bundle for edge_map_packer
interface edge_map_packer_if;
  logic       bit_in;
  logic       bit_valid;
  logic       bit_ready;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;
  logic       byte_last;

  // master is the packer side; slave is the buffer/host-link side
  modport master (
    input  bit_in, bit_valid, byte_ready,
    output bit_ready, byte_out, byte_valid, byte_last
  );

  modport slave (
    output bit_in, bit_valid, byte_ready,
    input  bit_ready, byte_out, byte_valid, byte_last
  );
endinterface

// File: rtl/edge_map_packer.sv
// rtl/edge_map_packer.sv - packs a 1-bit-per-pixel edge frame MSB-first into bytes behind a small FIFO
module edge_map_packer #(
  parameter int NUM_PIXELS = 22500,
  parameter int CNT_W      = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enb,
  input  logic              start,
  edge_map_packer_if.master bus,
  output logic [CNT_W-1:0]  pix_cnt,
  output logic              complete
);
  localparam int               AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]      FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]      ONE_CNT  = (AW+1)'(1);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {IDLE, PACK, FLUSH, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [7:0]    sreg;
  logic [2:0]    bit_cnt;
  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          fifo_full, fifo_empty, last_pix;
  logic          bit_rdy, accept, pop;
  logic          push, push_last, frame_start, set_complete;
  logic [7:0]    push_data;

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign last_pix   = (pix_cnt == LAST_PIX);

  // the 8th bit of a byte can only be taken if its byte has somewhere to go
  assign bit_rdy = (state == PACK) && enb && ((bit_cnt != 3'd7) || !fifo_full);
  assign accept  = bus.bit_valid && bit_rdy;

  assign bus.bit_ready  = bit_rdy;
  assign bus.byte_valid = enb && !fifo_empty;
  assign bus.byte_out   = mem[rd_ptr][7:0];
  assign bus.byte_last  = mem[rd_ptr][8];
  assign pop            = bus.byte_valid && bus.byte_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    push         = 1'b0;
    push_data    = {sreg[6:0], bus.bit_in};
    push_last    = last_pix;
    frame_start  = 1'b0;
    set_complete = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start && enb) begin
          frame_start = 1'b1;
          state_nxt   = PACK;
        end
      end
      PACK: begin
        if (accept) begin
          push = (bit_cnt == 3'd7);
          if (last_pix) state_nxt = (bit_cnt == 3'd7) ? DRAIN : FLUSH;
        end
      end
      FLUSH: begin
        // left-align the partial byte so the unused low bits are zero padding
        if (enb && !fifo_full) begin
          push      = 1'b1;
          push_data = sreg << (4'd8 - {1'b0, bit_cnt});
          push_last = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (count == ONE_CNT)) begin
          set_complete = 1'b1;
          state_nxt    = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg     <= '0;
      bit_cnt  <= '0;
      pix_cnt  <= '0;
      complete <= 1'b0;
    end else if (frame_start) begin
      sreg     <= '0;
      bit_cnt  <= '0;
      pix_cnt  <= '0;
      complete <= 1'b0;
    end else begin
      if (accept) begin
        sreg    <= {sreg[6:0], bus.bit_in};
        bit_cnt <= bit_cnt + 3'd1;
        pix_cnt <= pix_cnt + CNT_W'(1);
      end
      if (set_complete) complete <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {push_last, push_data};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_edge_map_packer.sv
// tb/tb_edge_map_packer.sv - directed self-checking bench for edge_map_packer
module tb_edge_map_packer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_b, rst_s, b_enb, s_enb, b_start, s_start;
  logic [14:0] b_pix;
  logic [4:0]  s_pix;
  logic        b_cpl, s_cpl;

  edge_map_packer_if bi();
  edge_map_packer_if si();

  edge_map_packer dut_big (
    .clk(clk), .reset(rst_b), .enb(b_enb), .start(b_start),
    .bus(bi), .pix_cnt(b_pix), .complete(b_cpl)
  );

  edge_map_packer #(.NUM_PIXELS(16), .CNT_W(5), .FIFO_DEPTH(2)) dut_small (
    .clk(clk), .reset(rst_s), .enb(s_enb), .start(s_start),
    .bus(si), .pix_cnt(s_pix), .complete(s_cpl)
  );

  int checks = 0;
  int errors = 0;
  int timeouts = 0;
  int b_acc = 0;
  logic [8:0] bq[$];
  logic [8:0] sq[$];
  time b_last_t = 0;
  time b_cpl_t = 0;
  logic b_cpl_q = 1'b0;

  always @(posedge clk) begin
    if (bi.byte_valid && bi.byte_ready) begin
      bq.push_back({bi.byte_last, bi.byte_out});
      if (bi.byte_last) b_last_t <= $time;
    end
    if (si.byte_valid && si.byte_ready) sq.push_back({si.byte_last, si.byte_out});
    if (bi.bit_valid && bi.bit_ready) b_acc <= b_acc + 1;
    if (b_cpl && !b_cpl_q) b_cpl_t <= $time;
    b_cpl_q <= b_cpl;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input bit sel, input string tag);
    if (sel) begin
      chk({tag, "_bit_ready"},  32'(si.bit_ready),  0);
      chk({tag, "_byte_valid"}, 32'(si.byte_valid), 0);
      chk({tag, "_byte_out"},   32'(si.byte_out),   0);
      chk({tag, "_byte_last"},  32'(si.byte_last),  0);
      chk({tag, "_pix_cnt"},    32'(s_pix),         0);
      chk({tag, "_complete"},   32'(s_cpl),         0);
    end else begin
      chk({tag, "_bit_ready"},  32'(bi.bit_ready),  0);
      chk({tag, "_byte_valid"}, 32'(bi.byte_valid), 0);
      chk({tag, "_byte_out"},   32'(bi.byte_out),   0);
      chk({tag, "_byte_last"},  32'(bi.byte_last),  0);
      chk({tag, "_pix_cnt"},    32'(b_pix),         0);
      chk({tag, "_complete"},   32'(b_cpl),         0);
    end
  endtask

  // one pixel per call: present at negedge, wait (bounded) for ready, return after the accepting edge
  task automatic send(input bit sel, input logic b);
    int t;
    @(negedge clk);
    if (sel) begin si.bit_in = b; si.bit_valid = 1'b1; s_enb = 1'b1; end
    else     begin bi.bit_in = b; bi.bit_valid = 1'b1; b_enb = 1'b1; end
    #1;
    t = 0;
    while (!(sel ? si.bit_ready : bi.bit_ready) && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 100) timeouts++;
    else @(posedge clk);
  endtask

  task automatic send_bits(input bit sel, input logic [7:0] v, input int n);
    logic [7:0] w;
    w = v;
    for (int i = n - 1; i >= 0; i--) send(sel, w[i]);
  endtask

  task automatic pulse_start(input bit sel);
    @(negedge clk);
    if (sel) begin s_start = 1'b1; si.bit_valid = 1'b0; end
    else     begin b_start = 1'b1; bi.bit_valid = 1'b0; end
    @(negedge clk);
    s_start = 1'b0;
    b_start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, acc0, bad, t;
    logic [8:0] exp9;
    rst_b = 1'b1; rst_s = 1'b1; b_enb = 1'b1; s_enb = 1'b1;
    b_start = 1'b0; s_start = 1'b0;
    bi.bit_in = 1'b0; bi.bit_valid = 1'b0; bi.byte_ready = 1'b0;
    si.bit_in = 1'b0; si.bit_valid = 1'b0; si.byte_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle(0, "b_rst");
    chk_idle(1, "s_rst");
    rst_b = 1'b0; rst_s = 1'b0;

    // small frame, sink always ready: B1 then 0F(last), last byte visible one cycle after its bit
    si.byte_ready = 1'b1;
    pulse_start(1);
    send_bits(1, 8'hB1, 8);
    send_bits(1, 8'h0F, 8);
    @(negedge clk);
    chk("s_lat_valid", 32'(si.byte_valid), 1);
    chk("s_lat_byte",  32'(si.byte_out), 32'h0F);
    chk("s_lat_last",  32'(si.byte_last), 1);
    chk("s_pix16",     32'(s_pix), 16);
    chk("s_extra_rdy", 32'(si.bit_ready), 0);
    @(negedge clk);
    chk("s_complete",  32'(s_cpl), 1);
    chk("s_nbytes",    32'(sq.size()), 2);
    chk("s_byte0",     32'(sq[0]), 32'h0B1);
    chk("s_byte1",     32'(sq[1]), 32'h10F);

    // DONE: bit_valid held high without start
    repeat (3) @(negedge clk);
    chk("s_done_rdy",  32'(si.bit_ready), 0);
    chk("s_done_nb",   32'(sq.size()), 2);
    chk("s_done_cpl",  32'(s_cpl), 1);
    chk("s_done_bv",   32'(si.byte_valid), 0);
    pulse_start(1);
    chk("s_restart_cpl", 32'(s_cpl), 0);
    chk("s_restart_pix", 32'(s_pix), 0);

    // depth-2 FIFO with sink stalled: both bytes queued, head stable, then drained in order
    si.byte_ready = 1'b0;
    send_bits(1, 8'hB1, 8);
    send_bits(1, 8'h0F, 8);
    @(negedge clk);
    chk("s_stall_bv",   32'(si.byte_valid), 1);
    chk("s_stall_head", 32'(si.byte_out), 32'hB1);
    chk("s_stall_last", 32'(si.byte_last), 0);
    chk("s_stall_rdy",  32'(si.bit_ready), 0);
    repeat (3) @(negedge clk);
    chk("s_hold_head",  32'(si.byte_out), 32'hB1);
    chk("s_hold_cpl",   32'(s_cpl), 0);
    si.byte_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("s_drain_nb",   32'(sq.size()), 4);
    chk("s_drain_b0",   32'(sq[2]), 32'h0B1);
    chk("s_drain_b1",   32'(sq[3]), 32'h10F);
    chk("s_drain_cpl",  32'(s_cpl), 1);

    // big DUT: enb stall mid-byte, then fill the FIFO and hit the bit_cnt=7 block
    base = bq.size();
    bi.byte_ready = 1'b0;
    pulse_start(0);
    send_bits(0, 8'h16, 5);
    repeat (3) begin
      @(negedge clk);
      b_enb = 1'b0;
      #1;
      chk("b_enb_pix", 32'(b_pix), 5);
      chk("b_enb_rdy", 32'(bi.bit_ready), 0);
      chk("b_enb_bv",  32'(bi.byte_valid), 0);
    end
    send_bits(0, 8'h01, 3);
    send_bits(0, 8'h0F, 8);
    send_bits(0, 8'h0F, 8);
    send_bits(0, 8'h0F, 8);
    send_bits(0, 8'h66, 7);
    @(negedge clk);
    bi.bit_in = 1'b1;
    #1;
    chk("b_full_rdy",  32'(bi.bit_ready), 0);
    chk("b_full_pix",  32'(b_pix), 39);
    chk("b_full_bv",   32'(bi.byte_valid), 1);
    chk("b_full_head", 32'(bi.byte_out), 32'hB1);
    @(negedge clk);
    bi.byte_ready = 1'b1;
    #1;
    chk("b_popsame_rdy", 32'(bi.bit_ready), 0);
    send(0, 1'b1);
    @(negedge clk);
    bi.byte_ready = 1'b0;
    bi.bit_valid = 1'b0;
    chk("b_pre_nb",   32'(bq.size() - base), 2);
    chk("b_pre_b0",   32'(bq[base]), 32'h0B1);
    chk("b_pre_b1",   32'(bq[base + 1]), 32'h00F);
    chk("b_pre_head", 32'(bi.byte_out), 32'h0F);

    // reset mid-frame discards queued bytes
    rst_b = 1'b1;
    #1;
    chk_idle(0, "b_midrst");
    @(negedge clk);
    rst_b = 1'b0;
    bi.byte_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("b_post_rst_nb", 32'(bq.size() - base), 2);
    pulse_start(0);
    send_bits(0, 8'hB1, 8);
    send_bits(0, 8'h0F, 8);
    @(negedge clk);
    bi.bit_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("b_new_nb",  32'(bq.size() - base), 4);
    chk("b_new_b0",  32'(bq[base + 2]), 32'h0B1);
    chk("b_new_b1",  32'(bq[base + 3]), 32'h00F);
    chk("b_new_pix", 32'(b_pix), 16);

    // full default frame of all ones, sink always ready, extra bits offered afterwards
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    base = bq.size();
    acc0 = b_acc;
    pulse_start(0);
    for (int k = 0; k < 22500; k++) send(0, 1'b1);
    t = 0;
    while (!b_cpl && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("ones_complete", 32'(b_cpl), 1);
    repeat (3) @(negedge clk);
    chk("ones_acc",     32'(b_acc - acc0), 22500);
    chk("ones_pix",     32'(b_pix), 22500);
    chk("ones_rdy",     32'(bi.bit_ready), 0);
    chk("ones_nbytes",  32'(bq.size() - base), 2813);
    bad = 0;
    for (int k = 0; k < 2813; k++) begin
      exp9 = (k == 2812) ? 9'h1F0 : 9'h0FF;
      if (base + k >= bq.size() || bq[base + k] !== exp9) bad++;
    end
    chk("ones_bad",     32'(bad), 0);
    chk("ones_tail",    32'(bq[bq.size() - 1]), 32'h1F0);
    chk("ones_cpl_lat", 32'(b_cpl_t - b_last_t), 10);
    chk("timeouts",     32'(timeouts), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
